// File: rtl/sdram_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_bridge_pkg
// Brief   : Shared widths, beat count and FSM state type for the wide bridge.
// Revision: 1.0 - initial release
// ============================================================================
package sdram_bridge_pkg;

    localparam int BEATS     = 8;
    localparam int AR_ADDR_W = 22;
    localparam int AR_DATA_W = 128;
    localparam int M_DATA_W  = 16;
    localparam int M_ADDR_W  = 25;

    localparam int AR_BE_W   = AR_DATA_W / 8;
    localparam int M_BE_W    = M_DATA_W / 8;
    localparam int BEAT_W    = $clog2(BEATS);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR       = 3'd1,
        RD       = 3'd2,
        RD_DRAIN = 3'd3,
        ACK      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sdram_wide_bridge.sv
`default_nettype none
// ============================================================================
// Module  : sdram_wide_bridge
// Brief   : Splits 128-bit requests into eight 16-bit memory beats and
//           reassembles read data into one wide word.
// Revision: 1.0 - initial release
// ============================================================================
module sdram_wide_bridge
    import sdram_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AR_ADDR_W-1:0] ar_addr,
    input  logic [AR_BE_W-1:0]   ar_be,
    input  logic                 ar_read,
    input  logic                 ar_write,
    input  logic [AR_DATA_W-1:0] ar_wrdata,
    output logic [AR_DATA_W-1:0] ar_rddata,
    output logic                 ar_ac,
    output logic [M_ADDR_W-1:0]  m_address,
    output logic                 m_read,
    output logic                 m_write,
    output logic [M_DATA_W-1:0]  m_writedata,
    output logic [M_BE_W-1:0]    m_byteenable,
    input  logic                 m_waitrequest,
    input  logic [M_DATA_W-1:0]  m_readdata,
    input  logic                 m_readdatavalid,
    output logic                 busy
);

    localparam int RCV_W = BEAT_W + 1;

    state_t               r_state;
    logic [AR_ADDR_W-1:0] r_addr;
    logic [AR_BE_W-1:0]   r_be;
    logic [AR_DATA_W-1:0] r_wdata;
    logic [BEAT_W-1:0]    r_beat;
    logic [RCV_W-1:0]     r_rcv;

    logic [BEAT_W-1:0]    w_beat_nxt;
    logic                 w_last_beat;
    logic                 w_rd_take;
    logic [RCV_W-1:0]     w_rcv_nxt;
    logic                 w_rcv_full;

    assign w_beat_nxt  = r_beat + BEAT_W'(1);
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    // Returned beats are only accepted while a read is open and not yet complete
    assign w_rd_take   = m_readdatavalid
                       && ((r_state == RD) || (r_state == RD_DRAIN))
                       && (r_rcv != RCV_W'(BEATS));
    assign w_rcv_nxt   = r_rcv + RCV_W'(w_rd_take);
    assign w_rcv_full  = (w_rcv_nxt == RCV_W'(BEATS));
    assign busy        = (r_state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_beat       <= '0;
            r_rcv        <= '0;
            ar_rddata    <= '0;
            ar_ac        <= 1'b0;
            m_address    <= '0;
            m_read       <= 1'b0;
            m_write      <= 1'b0;
            m_writedata  <= '0;
            m_byteenable <= '0;
        end else begin
            if (w_rd_take) begin
                ar_rddata[{r_rcv[BEAT_W-1:0], 4'b0000} +: M_DATA_W] <= m_readdata;
                r_rcv <= w_rcv_nxt;
            end

            case (r_state)
                IDLE: begin
                    ar_ac  <= 1'b0;
                    r_beat <= '0;
                    if (ar_read || ar_write) begin
                        r_addr    <= ar_addr;
                        r_be      <= ar_be;
                        r_wdata   <= ar_wrdata;
                        r_rcv     <= '0;
                        m_address <= {ar_addr, BEAT_W'(0)};
                        // A read wins when both strobes are presented together
                        if (ar_read) begin
                            r_state      <= RD;
                            m_read       <= 1'b1;
                            m_byteenable <= '1;
                        end else begin
                            r_state      <= WR;
                            m_write      <= 1'b1;
                            m_writedata  <= ar_wrdata[M_DATA_W-1:0];
                            m_byteenable <= ar_be[M_BE_W-1:0];
                        end
                    end
                end

                WR: begin
                    if (!m_waitrequest) begin
                        if (w_last_beat) begin
                            m_write <= 1'b0;
                            ar_ac   <= 1'b1;
                            r_state <= ACK;
                        end else begin
                            r_beat       <= w_beat_nxt;
                            m_address    <= {r_addr, w_beat_nxt};
                            m_writedata  <= r_wdata[{w_beat_nxt, 4'b0000} +: M_DATA_W];
                            m_byteenable <= r_be[{w_beat_nxt, 1'b0} +: M_BE_W];
                        end
                    end
                end

                RD: begin
                    if (!m_waitrequest) begin
                        if (w_last_beat) begin
                            m_read <= 1'b0;
                            if (w_rcv_full) begin
                                ar_ac   <= 1'b1;
                                r_state <= ACK;
                            end else begin
                                r_state <= RD_DRAIN;
                            end
                        end else begin
                            r_beat    <= w_beat_nxt;
                            m_address <= {r_addr, w_beat_nxt};
                        end
                    end
                end

                RD_DRAIN: begin
                    if (w_rcv_full) begin
                        ar_ac   <= 1'b1;
                        r_state <= ACK;
                    end
                end

                ACK: begin
                    ar_ac   <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    ar_ac   <= 1'b0;
                    m_read  <= 1'b0;
                    m_write <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sdram_wide_bridge.md
SDRAM_WIDE_BRIDGE -- requirements
Module: sdram_wide_bridge

Interface
REQ-001 SHALL have one clock and async active-high reset: clk in 1 rising-edge clock; reset in 1 async active-high reset.
REQ-002 SHALL expose responder port: ar_addr in 22 128-bit-word address; ar_be in 16 byte enables (write only); ar_read in 1; ar_write in 1; ar_wrdata in 128; ar_rddata out 128; ar_ac out 1 one-cycle acknowledge.
REQ-003 SHALL expose memory master port: m_address out 25 16-bit-word address; m_read out 1; m_write out 1; m_writedata out 16; m_byteenable out 2; m_waitrequest in 1; m_readdata in 16; m_readdatavalid in 1.
REQ-004 SHALL expose busy out 1: high whenever state is not IDLE.

Function
REQ-005 Requester holds ar_read/ar_write and its fields stable until ar_ac; bridge SHALL sample a request only in IDLE.
REQ-006 Both ar_read and ar_write high in IDLE: read SHALL be serviced, write ignored.
REQ-007 On acceptance, ar_addr/ar_be/ar_wrdata SHALL be latched; later requester changes SHALL not affect the transaction.
REQ-008 Beat i (0..7) SHALL use m_address = {latched addr, i[2:0]}, data bits [16i+15:16i], byteenable be[2i+1:2i].
REQ-009 States: IDLE, WR, RD, RD_DRAIN, ACK.
REQ-010 IDLE: ar_write -> WR; ar_read -> RD; else stay.
REQ-011 WR: m_write high, beat counter advances only when m_waitrequest low; after beat 7 accepted -> ACK.
REQ-012 Beats with byteenable 2'b00 SHALL still be issued (fixed 8 beats).
REQ-013 RD: m_read high, m_byteenable 2'b11, issue counter advances when m_waitrequest low; after command 7 accepted -> RD_DRAIN (or ACK if all 8 data returned).
REQ-014 Read data SHALL be collected concurrently with issue; k-th m_readdatavalid beat (k=0..7) SHALL be stored at ar_rddata[16k+15:16k]; 4-bit receive counter.
REQ-015 RD_DRAIN: m_read low; when receive count reaches 8 -> ACK.
REQ-016 ACK: ar_ac high exactly one cycle, -> IDLE; new request sampled no earlier than next cycle.
REQ-017 ar_rddata SHALL hold assembled data from ACK until next read's first returned beat; unchanged by writes.
REQ-018 m_readdatavalid outside RD/RD_DRAIN, or after 8 beats received, SHALL be ignored.
REQ-019 m_read and m_write SHALL never be high together; both low in IDLE, RD_DRAIN, ACK.
REQ-020 Latency, zero waitrequest: write ar_ac 10 cycles after the IDLE cycle sampling the request (1 accept + 8 beats + ACK); read with fixed memory latency L: ar_ac at cycle 1+8+L after acceptance sample.
REQ-021 m_address, m_writedata, m_byteenable SHALL be stable while m_waitrequest high with a command asserted.

Reset
REQ-022 Reset SHALL force IDLE, clear counters, drive ar_ac=0, m_read=0, m_write=0, busy=0, ar_rddata=0, m_address=0, m_writedata=0, m_byteenable=0 asynchronously.
REQ-023 Reset mid-transaction SHALL abandon it without ar_ac; stale m_readdatavalid after reset SHALL be ignored per REQ-018.

Structure
REQ-024 Shared package sdram_bridge_pkg SHALL hold state enum, BEATS=8, AR_ADDR_W=22, AR_DATA_W=128, M_DATA_W=16, M_ADDR_W=25.
REQ-025 Single flat module, no sub-module; beat/receive counters and 128-bit latch registers inline.

Verification
REQ-026 Write addr 22'h000010, be 16'hFFFF, data 128'h000F_000E_..._0000 (beat i = i), no waitrequest -> m_address 25'h80..87, writedata 0..7, ar_ac cycle 10, then idle.
REQ-027 Read addr 22'h3FFFFF, memory latency 2, beat data 16'hA000+k -> m_address 25'h1FFFFF8..1FFFFFF, ar_rddata = {16'hA007,...,16'hA000}, ar_ac cycle 11.
REQ-028 Write with m_waitrequest high 3 cycles on beat 4, ar_be 16'h00F0 -> beat 4 held 4 cycles, byteenables 00,00,11,11,00,00,00,00, ar_ac cycle 13.
REQ-029 ar_read and ar_write both high -> only m_read beats issued, one ar_ac, m_write never high.
REQ-030 Reset asserted after read beat 3 returned -> all outputs zero immediately, no ar_ac; 4 late readdatavalid beats ignored; next write completes normally.
REQ-031 Back-to-back reads held after ar_ac -> second read accepted exactly one cycle after ACK, first ar_rddata held until second read's first beat.
